// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential 16x16 signed radix-2 Booth multiplier.
// One add/subtract/pass step per clock on a 16-bit signed adder datapath.
// The handshake is start/busy/done, and product holds until the next accepted start.
// The adder carry-out and zero flag play no part here, so the datapath
// computes only the sum and the overflow it needs.
module booth_mult_seq #(
  parameter int unsigned N_ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(N_ITER - 1);

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;      // A: upper half of the product
  logic [15:0] mq_q, mq_d;        // Q: multiplier / lower half of the product
  logic        q1_q, q1_d;        // Booth extra bit
  logic [15:0] mcand_q, mcand_d;  // M: multiplicand
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;

  // Adder control and step result
  logic        do_sub, do_add;
  logic        add_op, add_cin;
  logic [15:0] add_y, add_sum;
  logic        add_ov;
  logic [15:0] step_r;
  logic        step_s;
  logic [15:0] acc_next, mq_next;

  // One Booth step: select add/sub/pass, recover the true sign, then shift.
  always_comb begin
    do_sub  = mq_q[0] & ~q1_q;
    do_add  = ~mq_q[0] & q1_q;
    add_op  = do_sub;
    add_cin = do_sub;
    add_y   = add_op ? ~mcand_q : mcand_q;
    add_sum = acc_q + add_y + {15'd0, add_cin};
    add_ov  = (acc_q[15] == add_y[15]) && (add_sum[15] != acc_q[15]);
    // A+-M can overflow 16 bits; the overflow-corrected sign bit keeps the
    // arithmetic right shift exact even for M = -32768.
    if (do_sub || do_add) begin
      step_r = add_sum;
      step_s = add_sum[15] ^ add_ov;
    end else begin
      step_r = acc_q;
      step_s = acc_q[15];
    end
    acc_next = {step_s, step_r[15:1]};
    mq_next  = {step_r[0], mq_q[15:1]};
  end

  // Next-state and register updates for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    q1_d      = q1_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_next;
        mq_d  = mq_next;
        q1_d  = mq_q[0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          product_d = {acc_next, mq_next};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mq_q      <= '0;
      q1_q      <= 1'b0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      q1_q      <= q1_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed vector table plus hand-written handshake,
// reset and random sequences for booth_mult_seq.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_vec;
  int n_err;

  booth_mult_seq #(.N_ITER(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one start and watch the whole operation cycle by cycle.
  task automatic do_mult(input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] exp, input string nm, input bit full);
    int busy_cnt, done_cnt, done_at, hold_bad;
    logic [31:0] prev, at_done;
    busy_cnt = 0; done_cnt = 0; done_at = -1; hold_bad = 0; at_done = '0;
    @(negedge clk);
    prev  = product;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);           // edge 0 sampled start
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
        at_done = product;
      end
      if (i < 16 && product !== prev) hold_bad++;
      if (i > 0 && !busy) break;
      @(negedge clk);
    end
    check({nm, "_product"}, at_done, exp);
    check({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
    if (full) begin
      check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd17);
      check({nm, "_done_edge"}, 32'(done_at), 32'd16);
      check({nm, "_product_hold"}, 32'(hold_bad), 32'd0);
      check({nm, "_product_after"}, product, exp);
    end
  endtask

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int done_cnt, first_done, second_done;
    logic busy17, busy18;
    logic [31:0] p16, p34, ex;
    logic [15:0] ra, rb;

    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0]  = '{16'h0003, 16'h0004, 32'h0000000C, "basic_3x4"};
    vecs[1]  = '{16'h8000, 16'h8000, 32'h40000000, "min_x_min"};
    vecs[2]  = '{16'h7FFF, 16'h8000, 32'hC0008000, "max_x_min"};
    vecs[3]  = '{16'hFFFF, 16'h0001, 32'hFFFFFFFF, "m1_x_1"};
    vecs[4]  = '{16'h0000, 16'h1234, 32'h00000000, "zero_a"};
    vecs[5]  = '{16'hABCD, 16'h0000, 32'h00000000, "zero_b"};
    vecs[6]  = '{16'hFFF9, 16'h0003, 32'hFFFFFFEB, "m7_x_3"};
    vecs[7]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, "max_x_max"};
    vecs[8]  = '{16'h8000, 16'h7FFF, 32'hC0008000, "min_x_max"};
    vecs[9]  = '{16'h8000, 16'h0001, 32'hFFFF8000, "min_x_1"};
    vecs[10] = '{16'h04D2, 16'hFFFF, 32'hFFFFFB2E, "1234_x_m1"};
    vecs[11] = '{16'hFFFF, 16'hFFFF, 32'h00000001, "m1_x_m1"};
    vecs[12] = '{16'h1234, 16'h0010, 32'h00012340, "shift4"};
    vecs[13] = '{16'hFF9C, 16'hFF38, 32'h00004E20, "m100_x_m200"};

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", product, 32'h00000000);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[k]) do_mult(vecs[k].va, vecs[k].vb, vecs[k].exp, vecs[k].nm, 1'b1);

    // Start pulses while busy are ignored and do not queue.
    done_cnt = 0;
    p16 = '0;
    @(negedge clk);
    a = 16'd5; b = 16'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 26; i++) begin
      if (done) begin
        done_cnt++;
        p16 = product;
      end
      if (i >= 5 && i <= 8) begin
        start = 1'b1; a = 16'd7; b = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_start_product", p16, 32'h0000001E);
    check("busy_start_done_cnt", 32'(done_cnt), 32'd1);
    check("busy_start_idle", {31'd0, busy}, 32'd0);
    check("busy_start_product_kept", product, 32'h0000001E);

    // Start held high: second operation accepted on the edge after DONE.
    done_cnt = 0; first_done = -1; second_done = -1;
    busy17 = 1'b1; busy18 = 1'b0; p16 = '0; p34 = '0;
    @(negedge clk);
    a = 16'd5; b = 16'd6; start = 1'b1;
    @(negedge clk);
    a = 16'd7; b = 16'd7;
    for (int i = 0; i < 40; i++) begin
      if (i == 17) busy17 = busy;
      if (i == 18) begin
        busy18 = busy;
        start  = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = i;
          p16 = product;
        end else begin
          second_done = i;
          p34 = product;
        end
      end
      @(negedge clk);
    end
    check("held_start_done_cnt", 32'(done_cnt), 32'd2);
    check("held_start_first_edge", 32'(first_done), 32'd16);
    check("held_start_second_edge", 32'(second_done), 32'd34);
    check("held_start_gap_idle", {31'd0, busy17}, 32'd0);
    check("held_start_reaccept", {31'd0, busy18}, 32'd1);
    check("held_start_first_prod", p16, 32'h0000001E);
    check("held_start_second_prod", p34, 32'h00000031);

    // Mid-operation reset discards the partial result.
    @(negedge clk);
    a = 16'd100; b = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_product", product, 32'h00000000);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    do_mult(16'd100, 16'd200, 32'h00004E20, "after_rst", 1'b1);

    // Random signed pairs against a 32-bit signed reference product.
    for (int r = 0; r < 2000; r++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ex = $signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb});
      do_mult(ra, rb, ex, "random", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
